// File: rtl/meas_gate_ctrl.sv
// Equal-precision gate controller: opens/closes the gate on fx edges, counts sys_clk
// cycles and fx periods, and publishes results only while the SPI bus is idle.
module meas_gate_ctrl #(
    parameter int unsigned GATE_CYCLES    = 200_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 400_000_000,
    parameter int unsigned CNT_W          = 32
) (
    input  logic             sys_clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             fx_in,
    input  logic             ncs,
    output logic [CNT_W-1:0] fs_cnt,
    output logic [CNT_W-1:0] fx_cnt,
    output logic             upd,
    output logic             nosig,
    output logic             ovf,
    output logic             busy,
    output logic [7:0]       seq
);

    localparam int unsigned GW = $clog2(GATE_CYCLES + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_GATE,
        ST_CLOSE,
        ST_PUBLISH
    } state_t;

    state_t           state_q, state_d;
    logic             fx_s0_q, fx_s1_q, fx_s2_q;
    logic             ncs_s0_q, ncs_s1_q;
    logic [CNT_W-1:0] fs_acc_q, fs_acc_d;
    logic [CNT_W-1:0] fx_acc_q, fx_acc_d;
    logic [GW-1:0]    gate_cnt_q, gate_cnt_d;
    logic [TW-1:0]    to_cnt_q, to_cnt_d;
    logic             ovf_p_q, ovf_p_d;
    logic [CNT_W-1:0] pend_fs_q, pend_fs_d;
    logic [CNT_W-1:0] pend_fx_q, pend_fx_d;
    logic             pend_ovf_q, pend_ovf_d;
    logic             pend_nosig_q, pend_nosig_d;
    logic [CNT_W-1:0] fs_cnt_q, fs_cnt_d;
    logic [CNT_W-1:0] fx_cnt_q, fx_cnt_d;
    logic             upd_q, upd_d;
    logic             nosig_q, nosig_d;
    logic             ovf_q, ovf_d;
    logic             busy_q;
    logic [7:0]       seq_q, seq_d;

    logic             fx_edge;
    logic             bus_idle;
    logic [CNT_W-1:0] fs_inc, fx_inc;
    logic             fs_full, fx_full;
    logic             to_hit;
    logic             to_fire;

    assign fx_edge  = fx_s1_q & ~fx_s2_q;
    assign bus_idle = ncs_s1_q;

    // Saturating increments: accumulators stick at all-ones instead of wrapping.
    assign fs_inc  = (fs_acc_q == '1) ? fs_acc_q : fs_acc_q + CNT_W'(1);
    assign fx_inc  = (fx_acc_q == '1) ? fx_acc_q : fx_acc_q + CNT_W'(1);
    assign fs_full = (fs_inc == '1);
    assign fx_full = (fx_inc == '1);
    assign to_hit  = (to_cnt_q == TO_LAST);

    always_comb begin
        state_d      = state_q;
        fs_acc_d     = fs_acc_q;
        fx_acc_d     = fx_acc_q;
        gate_cnt_d   = gate_cnt_q;
        to_cnt_d     = to_cnt_q;
        ovf_p_d      = ovf_p_q;
        pend_fs_d    = pend_fs_q;
        pend_fx_d    = pend_fx_q;
        pend_ovf_d   = pend_ovf_q;
        pend_nosig_d = pend_nosig_q;
        fs_cnt_d     = fs_cnt_q;
        fx_cnt_d     = fx_cnt_q;
        nosig_d      = nosig_q;
        ovf_d        = ovf_q;
        seq_d        = seq_q;
        upd_d        = 1'b0;
        to_fire      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                    ovf_p_d = 1'b0;
                end else if (fx_edge) begin
                    fs_acc_d   = '0;
                    fx_acc_d   = '0;
                    gate_cnt_d = '0;
                    ovf_p_d    = 1'b0;
                    state_d    = ST_GATE;
                end else if (to_hit) begin
                    to_fire = 1'b1;
                end
            end
            ST_GATE: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else begin
                    fs_acc_d   = fs_inc;
                    gate_cnt_d = gate_cnt_q + GW'(1);
                    if (fs_full) begin
                        ovf_p_d = 1'b1;
                    end
                    if (fx_edge) begin
                        fx_acc_d = fx_inc;
                        if (fx_full) begin
                            ovf_p_d = 1'b1;
                        end
                    end
                    if (to_hit && !fx_edge) begin
                        to_fire = 1'b1;
                    end else if (gate_cnt_q == GATE_LAST) begin
                        state_d = ST_CLOSE;
                    end
                end
            end
            ST_CLOSE: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else begin
                    fs_acc_d = fs_inc;
                    // The closing edge takes priority over a coincident timeout.
                    if (fx_edge) begin
                        fx_acc_d     = fx_inc;
                        pend_fs_d    = fs_inc;
                        pend_fx_d    = fx_inc;
                        pend_ovf_d   = ovf_p_q | fs_full | fx_full;
                        pend_nosig_d = 1'b0;
                        state_d      = ST_PUBLISH;
                    end else if (to_hit) begin
                        to_fire = 1'b1;
                    end
                end
            end
            ST_PUBLISH: begin
                if (bus_idle) begin
                    fs_cnt_d = pend_fs_q;
                    fx_cnt_d = pend_fx_q;
                    ovf_d    = pend_ovf_q;
                    nosig_d  = pend_nosig_q;
                    seq_d    = seq_q + 8'd1;
                    upd_d    = 1'b1;
                    state_d  = enable ? ST_ARM : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (to_fire) begin
            pend_fs_d    = '0;
            pend_fx_d    = '0;
            pend_ovf_d   = 1'b0;
            pend_nosig_d = 1'b1;
            state_d      = ST_PUBLISH;
        end

        // Timeout counter restarts on every state change and every fx edge.
        if ((state_d != state_q) || fx_edge) begin
            to_cnt_d = '0;
        end else if ((state_q == ST_ARM) || (state_q == ST_GATE) || (state_q == ST_CLOSE)) begin
            to_cnt_d = to_cnt_q + TW'(1);
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            fx_s0_q      <= 1'b0;
            fx_s1_q      <= 1'b0;
            fx_s2_q      <= 1'b0;
            ncs_s0_q     <= 1'b1;
            ncs_s1_q     <= 1'b1;
            fs_acc_q     <= '0;
            fx_acc_q     <= '0;
            gate_cnt_q   <= '0;
            to_cnt_q     <= '0;
            ovf_p_q      <= 1'b0;
            pend_fs_q    <= '0;
            pend_fx_q    <= '0;
            pend_ovf_q   <= 1'b0;
            pend_nosig_q <= 1'b0;
            fs_cnt_q     <= '0;
            fx_cnt_q     <= '0;
            upd_q        <= 1'b0;
            nosig_q      <= 1'b0;
            ovf_q        <= 1'b0;
            busy_q       <= 1'b0;
            seq_q        <= '0;
        end else begin
            state_q      <= state_d;
            fx_s0_q      <= fx_in;
            fx_s1_q      <= fx_s0_q;
            fx_s2_q      <= fx_s1_q;
            ncs_s0_q     <= ncs;
            ncs_s1_q     <= ncs_s0_q;
            fs_acc_q     <= fs_acc_d;
            fx_acc_q     <= fx_acc_d;
            gate_cnt_q   <= gate_cnt_d;
            to_cnt_q     <= to_cnt_d;
            ovf_p_q      <= ovf_p_d;
            pend_fs_q    <= pend_fs_d;
            pend_fx_q    <= pend_fx_d;
            pend_ovf_q   <= pend_ovf_d;
            pend_nosig_q <= pend_nosig_d;
            fs_cnt_q     <= fs_cnt_d;
            fx_cnt_q     <= fx_cnt_d;
            upd_q        <= upd_d;
            nosig_q      <= nosig_d;
            ovf_q        <= ovf_d;
            busy_q       <= (state_d != ST_IDLE);
            seq_q        <= seq_d;
        end
    end

    assign fs_cnt = fs_cnt_q;
    assign fx_cnt = fx_cnt_q;
    assign upd    = upd_q;
    assign nosig  = nosig_q;
    assign ovf    = ovf_q;
    assign busy   = busy_q;
    assign seq    = seq_q;

endmodule

// File: tb/tb_meas_gate_ctrl.sv
// Directed bench for meas_gate_ctrl: period table plus SPI-hold, timeout, abort,
// saturation and reset-mid-operation sequences.
module tb_meas_gate_ctrl;

    logic        sys_clk = 1'b0;
    logic        rst_n, enable, enable_s, fx_in, ncs;
    logic [31:0] fs_cnt, fx_cnt;
    logic        upd, nosig, ovf, busy;
    logic [7:0]  seq;
    logic [7:0]  fs_s, fx_s;
    logic        upd_s, nosig_s, ovf_s, busy_s;
    logic [7:0]  seq_s;

    int total = 0;
    int bad   = 0;
    int exp_seq;
    int fx_per;
    bit fx_run;

    always #5 sys_clk = ~sys_clk;

    meas_gate_ctrl #(.GATE_CYCLES(100), .TIMEOUT_CYCLES(500), .CNT_W(32)) dut (
        .sys_clk(sys_clk), .rst_n(rst_n), .enable(enable), .fx_in(fx_in), .ncs(ncs),
        .fs_cnt(fs_cnt), .fx_cnt(fx_cnt), .upd(upd), .nosig(nosig), .ovf(ovf),
        .busy(busy), .seq(seq)
    );

    meas_gate_ctrl #(.GATE_CYCLES(300), .TIMEOUT_CYCLES(500), .CNT_W(8)) dut_s (
        .sys_clk(sys_clk), .rst_n(rst_n), .enable(enable_s), .fx_in(fx_in), .ncs(ncs),
        .fs_cnt(fs_s), .fx_cnt(fx_s), .upd(upd_s), .nosig(nosig_s), .ovf(ovf_s),
        .busy(busy_s), .seq(seq_s)
    );

    typedef struct {
        int          per;
        logic [63:0] fs;
        logic [63:0] fx;
    } vec_t;

    vec_t vecs[7];

    // Square wave with an exact period of fx_per cycles, changing on negedges.
    initial begin
        int ph;
        ph    = 0;
        fx_in = 1'b0;
        forever begin
            @(negedge sys_clk);
            if (fx_run) begin
                fx_in = (ph < fx_per / 2);
                ph    = (ph + 1 >= fx_per) ? 0 : ph + 1;
            end else begin
                fx_in = 1'b0;
                ph    = 0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic wait_upd(input string name, input bit sel, output int n);
        n = 0;
        do begin
            @(negedge sys_clk);
            n++;
        end while (((sel ? upd_s : upd) !== 1'b1) && n < 3000);
        if ((sel ? upd_s : upd) !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL %s: no upd within %0d cycles", name, n);
        end
    endtask

    task automatic start_meas(input int per);
        enable = 1'b0;
        fx_run = 1'b0;
        cycles(5);
        fx_per = per;
        fx_run = 1'b1;
        enable = 1'b1;
    endtask

    initial begin
        int n;
        int n2;
        int chg;
        vecs = '{
            '{10,  64'd110, 64'd11},
            '{7,   64'd105, 64'd15},
            '{3,   64'd102, 64'd34},
            '{2,   64'd102, 64'd51},
            '{50,  64'd150, 64'd3},
            '{100, 64'd200, 64'd2},
            '{101, 64'd101, 64'd1}
        };
        rst_n    = 1'b0;
        enable   = 1'b0;
        enable_s = 1'b0;
        ncs      = 1'b1;
        fx_run   = 1'b0;
        fx_per   = 10;
        exp_seq  = 0;

        cycles(3);
        check("rst_fs", 64'(fs_cnt), 64'd0);
        check("rst_fx", 64'(fx_cnt), 64'd0);
        check("rst_flags", 64'({upd, nosig, ovf, busy}), 64'd0);
        check("rst_seq", 64'(seq), 64'd0);
        rst_n = 1'b1;
        cycles(3);

        for (int i = 0; i < 7; i++) begin
            start_meas(vecs[i].per);
            wait_upd("upd_first", 1'b0, n);
            exp_seq++;
            check("fs_first", 64'(fs_cnt), vecs[i].fs);
            check("fx_first", 64'(fx_cnt), vecs[i].fx);
            check("nosig_first", 64'(nosig), 64'd0);
            check("ovf_first", 64'(ovf), 64'd0);
            check("seq_first", 64'(seq), 64'(exp_seq));
            @(negedge sys_clk);
            check("upd_width", 64'(upd), 64'd0);
            wait_upd("upd_repeat", 1'b0, n);
            exp_seq++;
            check("fs_repeat", 64'(fs_cnt), vecs[i].fs);
            check("fx_repeat", 64'(fx_cnt), vecs[i].fx);
            check("seq_repeat", 64'(seq), 64'(exp_seq));
        end

        // Publish held off by an active SPI frame.
        start_meas(10);
        wait_upd("spi_pre_upd", 1'b0, n);
        exp_seq++;
        ncs = 1'b0;
        chg = 0;
        repeat (200) begin
            @(negedge sys_clk);
            if (upd !== 1'b0 || fs_cnt !== 32'd110 || fx_cnt !== 32'd11) chg++;
        end
        check("spi_hold_stable", 64'(chg), 64'd0);
        check("spi_hold_busy", 64'(busy), 64'd1);
        ncs = 1'b1;
        @(negedge sys_clk);
        check("spi_rel_1", 64'(upd), 64'd0);
        @(negedge sys_clk);
        check("spi_rel_2", 64'(upd), 64'd0);
        @(negedge sys_clk);
        check("spi_rel_3", 64'(upd), 64'd1);
        exp_seq++;
        check("spi_fs", 64'(fs_cnt), 64'd110);
        check("spi_fx", 64'(fx_cnt), 64'd11);
        check("spi_seq", 64'(seq), 64'(exp_seq));

        // No signal: fx held low, timeout publishes.
        enable = 1'b0;
        fx_run = 1'b0;
        cycles(5);
        enable = 1'b1;
        n = 0;
        do begin
            @(negedge sys_clk);
            n++;
        end while (busy !== 1'b1 && n < 20);
        check("nosig_arm", 64'(busy), 64'd1);
        wait_upd("nosig_upd", 1'b0, n);
        exp_seq++;
        check("nosig_latency", 64'(n >= 500 && n <= 501), 64'd1);
        check("nosig_fs", 64'(fs_cnt), 64'd0);
        check("nosig_fx", 64'(fx_cnt), 64'd0);
        check("nosig_flag", 64'(nosig), 64'd1);
        check("nosig_ovf", 64'(ovf), 64'd0);
        check("nosig_seq", 64'(seq), 64'(exp_seq));
        wait_upd("nosig_upd2", 1'b0, n2);
        exp_seq++;
        check("nosig_period", 64'(n2), 64'd501);
        check("nosig_seq2", 64'(seq), 64'(exp_seq));

        // Abort mid-gate.
        start_meas(10);
        wait_upd("abort_pre_upd", 1'b0, n);
        exp_seq++;
        check("abort_pre_fs", 64'(fs_cnt), 64'd110);
        check("abort_pre_nosig", 64'(nosig), 64'd0);
        cycles(30);
        check("abort_busy_pre", 64'(busy), 64'd1);
        enable = 1'b0;
        @(negedge sys_clk);
        check("abort_busy", 64'(busy), 64'd0);
        chg = 0;
        repeat (300) begin
            @(negedge sys_clk);
            if (upd !== 1'b0 || fs_cnt !== 32'd110 || fx_cnt !== 32'd11 || busy !== 1'b0) chg++;
        end
        check("abort_quiet", 64'(chg), 64'd0);
        check("abort_seq", 64'(seq), 64'(exp_seq));

        // Saturation on the 8-bit instance.
        fx_per   = 10;
        fx_run   = 1'b1;
        enable_s = 1'b1;
        wait_upd("sat_upd", 1'b1, n);
        check("sat_fs", 64'(fs_s), 64'd255);
        check("sat_fx", 64'(fx_s), 64'd31);
        check("sat_ovf", 64'(ovf_s), 64'd1);
        check("sat_nosig", 64'(nosig_s), 64'd0);
        check("sat_seq", 64'(seq_s), 64'd1);
        enable_s = 1'b0;

        // Reset while publish is held by SPI.
        start_meas(10);
        wait_upd("rstp_pre_upd", 1'b0, n);
        ncs = 1'b0;
        cycles(200);
        check("rstp_busy_pre", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rstp_fs", 64'(fs_cnt), 64'd0);
        check("rstp_fx", 64'(fx_cnt), 64'd0);
        check("rstp_flags", 64'({upd, nosig, ovf, busy}), 64'd0);
        check("rstp_seq", 64'(seq), 64'd0);
        @(negedge sys_clk);
        ncs   = 1'b1;
        rst_n = 1'b1;
        wait_upd("rstp_fresh_upd", 1'b0, n);
        check("rstp_fresh_fs", 64'(fs_cnt), 64'd110);
        check("rstp_fresh_fx", 64'(fx_cnt), 64'd11);
        check("rstp_fresh_seq", 64'(seq), 64'd1);

        // Reset during the gate.
        cycles(30);
        check("rstg_busy_pre", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rstg_fs", 64'(fs_cnt), 64'd0);
        check("rstg_fx", 64'(fx_cnt), 64'd0);
        check("rstg_flags", 64'({upd, nosig, ovf, busy}), 64'd0);
        check("rstg_seq", 64'(seq), 64'd0);
        @(negedge sys_clk);
        rst_n = 1'b1;
        wait_upd("rstg_fresh_upd", 1'b0, n);
        check("rstg_fresh_fs", 64'(fs_cnt), 64'd110);
        check("rstg_fresh_fx", 64'(fx_cnt), 64'd11);
        check("rstg_fresh_flags", 64'({nosig, ovf}), 64'd0);
        check("rstg_fresh_seq", 64'(seq), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/meas_gate_ctrl.md
# meas_gate_ctrl

Equal-precision gate controller for the cymometer. It opens and closes the measurement gate on edges of the signal under test, and counts both sys_clk cycles (fs) and fx edges over a whole number of fx periods. Results are published to the SPI readout path only while the SPI bus is idle, so a 96-bit SPI frame never mixes two measurements. It sits between the fx input pin and the SPI slave's fs_cnt/fx_cnt inputs.

## Interface
- GATE_CYCLES, 200_000_000: preset gate length in sys_clk cycles (1 s at 200 MHz).
- TIMEOUT_CYCLES, 400_000_000: cycles without an fx edge before "no signal" is declared.
- CNT_W, 32: width of the fs/fx counters and outputs.

- sys_clk  in  1  system clock, 200 MHz.
- rst_n  in  1  reset, asynchronous, active-low.
- enable  in  1  run continuous measurements while high (synchronous).
- fx_in  in  1  raw signal under test; asynchronous; requires f < sys_clk/2.
- ncs  in  1  raw SPI chip select, active low, asynchronous.
- fs_cnt  out  CNT_W  published sys_clk count.
- fx_cnt  out  CNT_W  published fx period count.
- upd  out  1  one-cycle pulse in the cycle the outputs change.
- nosig  out  1  last result was a timeout.
- ovf  out  1  last result saturated.
- busy  out  1  state is not IDLE.
- seq  out  8  publish counter; wraps 255→0.

## Operation
- **Synchronisers**
  - fx_in passes through 3 flops (s0, s1, s2); fx_edge = s1 & ~s2.
  - ncs passes through 2 flops (the same depth the SPI slave uses); bus_idle = ncs_s1.
- **States:** IDLE, ARM, GATE, CLOSE, PUBLISH.
- **IDLE:** enable=1 → ARM.
- **ARM:** waits for the opening edge.
  - On fx_edge: fs_acc←0, fx_acc←0, gate_cnt←0, → GATE.
- **GATE:**
  - Every cycle: fs_acc+1 and gate_cnt+1.
  - On fx_edge: fx_acc+1.
  - gate_cnt==GATE_CYCLES-1 → CLOSE.
- **CLOSE:**
  - Every cycle: fs_acc+1.
  - On fx_edge: fx_acc+1, latch pending←{fs_acc+1, fx_acc+1, ovf flag}, nosig_p←0, → PUBLISH.
- **PUBLISH:**
  - While bus_idle=0: wait, holding pending.
  - When bus_idle=1: fs_cnt/fx_cnt/ovf/nosig←pending, upd=1, seq+1.
  - Then → ARM if enable, else IDLE.
- **Timeout:**
  - to_cnt clears on state entry and on each fx_edge, and increments otherwise in ARM, GATE and CLOSE.
  - to_cnt==TIMEOUT_CYCLES-1 → pending fs=0, fx=0, ovf=0, nosig_p=1, → PUBLISH.
- **Saturation:** fs_acc and fx_acc hold at all-ones rather than wrapping. Reaching all-ones sets ovf_p, which is cleared on ARM exit.
- **enable=0 in ARM/GATE/CLOSE:** → IDLE on the next edge. Accumulators are discarded; outputs are unchanged; no upd.
- **enable=0 in PUBLISH:** the publish completes, then → IDLE.
- **Simultaneous events in CLOSE:** if the closing fx_edge and the timeout occur in the same cycle, the edge wins.

## Timing
- **Reset values:** fs_cnt=0, fx_cnt=0, upd=0, nosig=0, ovf=0, busy=0, seq=0, state=IDLE.
- **Reset mid-operation:** reset asserted in any state returns all of the above immediately (asynchronous).
- **Latency, closing edge to outputs:**
  - fx_in edge to fx_edge: 2–3 cycles.
  - fx_edge to PUBLISH: 1 cycle.
  - PUBLISH to outputs: 1 cycle when bus_idle.
  - Total ≤5 cycles from the pin edge to fs_cnt valid with upd=1.
- **Bus-busy rule:** outputs never change while ncs_s1=0. Publish occurs ≥2 cycles after the raw ncs rises, then 1 more cycle.
- **Accuracy:** the sync delay is identical at both gate ends, so it cancels. For an exact period of P cycles, fs_cnt = fx_cnt × P.
- **Gate length:** the gate lasts ≥ GATE_CYCLES and < GATE_CYCLES + one fx period (+1 cycle).
- **Re-arm:** ARM is entered the cycle after publish. The next opening edge is the first fx_edge seen in ARM.

## Test plan
- **Basic measurement:** GATE_CYCLES=100, TIMEOUT=500, fx period 10 cycles, enable=1 → fx_cnt=11, fs_cnt=110, upd one cycle, seq=1, nosig=0, ovf=0. Subsequent results are repeated and identical.
- **Publish held by SPI:** ncs held low across the closing edge for 50 cycles → fs_cnt/fx_cnt unchanged while ncs low. upd occurs exactly 3 cycles after ncs rises.
- **No signal:** fx_in constant, TIMEOUT=500 → upd 500 cycles after entering ARM, with fs_cnt=0, fx_cnt=0, nosig=1. Repeats every ~501 cycles.
- **Abort:** enable dropped mid-GATE → IDLE next cycle, busy=0, no upd, outputs retain the previous result.
- **Saturation:** CNT_W=8, GATE_CYCLES=300, fx period 10 → fs_cnt=255, fx_cnt=31, ovf=1.
- **Reset mid-operation:** rst_n pulsed low during GATE and during PUBLISH-wait → all outputs 0 immediately. After release, a fresh measurement gives the basic-measurement values with seq=1.
